// File: rtl/branch_sequencer.sv
// Execute-phase sequencer for conditional branches (brzr/brnz/brpl/brmi).
// Strobes the condition flip-flop once and captures its result. It then walks
// the datapath through PC + C and loads PC only when the branch is taken.
// It also keeps saturating taken/executed counters for debug visibility.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; a non-branch opcode raises illegal next cycle
// T3    | Gra, Rout, CON_enable; taken captured from con_out at closing edge
// T4    | PCout, Yin
// T5    | Cout, alu_add, Zin
// T6    | Zlowout, PCin gated by taken; counters update at closing edge
// FIN   | done pulse, then back to IDLE
module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b10010,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      IR,
    input  logic             con_out,
    output logic             Gra,
    output logic             Rout,
    output logic             CON_enable,
    output logic             PCout,
    output logic             Yin,
    output logic             Cout,
    output logic             alu_add,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCin,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] exec_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;

    logic             is_branch;
    logic             unused_ir;

    // Only the opcode field matters here; operand fields feed the datapath.
    assign is_branch = (IR[31:27] == BR_OPCODE);
    assign unused_ir = ^IR[26:0];

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start && is_branch) state_d = S_T3;
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = S_T6;
            S_T6:   state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the captured condition, illegal pulse and counters.
    always_comb begin
        taken_d     = taken_q;
        illegal_d   = 1'b0;
        taken_cnt_d = taken_cnt_q;
        exec_cnt_d  = exec_cnt_q;
        if (state_q == S_IDLE && start && !is_branch) begin
            illegal_d = 1'b1;
        end
        if (state_q == S_T3) begin
            taken_d = con_out;
        end
        if (state_q == S_T6) begin
            if (exec_cnt_q != CNT_MAX) begin
                exec_cnt_d = exec_cnt_q + CNT_ONE;
            end
            if (taken_q && (taken_cnt_q != CNT_MAX)) begin
                taken_cnt_d = taken_cnt_q + CNT_ONE;
            end
        end
    end

    // Flag and counter registers; clear wipes everything, including stats.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            taken_cnt_q <= '0;
            exec_cnt_q  <= '0;
        end else begin
            taken_q     <= taken_d;
            illegal_q   <= illegal_d;
            taken_cnt_q <= taken_cnt_d;
            exec_cnt_q  <= exec_cnt_d;
        end
    end

    // Moore output decode from state and registered flags only.
    always_comb begin
        Gra        = 1'b0;
        Rout       = 1'b0;
        CON_enable = 1'b0;
        PCout      = 1'b0;
        Yin        = 1'b0;
        Cout       = 1'b0;
        alu_add    = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_T3: begin
                Gra        = 1'b1;
                Rout       = 1'b1;
                CON_enable = 1'b1;
                busy       = 1'b1;
            end
            S_T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
                busy  = 1'b1;
            end
            S_T5: begin
                Cout    = 1'b1;
                alu_add = 1'b1;
                Zin     = 1'b1;
                busy    = 1'b1;
            end
            S_T6: begin
                Zlowout = 1'b1;
                PCin    = taken_q;
                busy    = 1'b1;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign taken     = taken_q;
    assign illegal   = illegal_q;
    assign taken_cnt = taken_cnt_q;
    assign exec_cnt  = exec_cnt_q;

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Execute-phase control sequencer for conditional branch instructions (brzr/brnz/brpl/brmi). It sits directly downstream of the condition flip-flop. It drives the CON enable strobe and captures the condition result. It then steps the datapath through target computation and gates PCin on the captured result. It also keeps saturating taken/executed branch counters for debug.

## Interface
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a conditional branch
- CNT_W, 16, width of both statistics counters
- clock  in  1  rising-edge system clock
- clear  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: IR holds a fetched instruction, execute phase may begin
- IR  in  32  current instruction; must stay stable from start until done
- con_out  in  1  condition flip-flop output (1 = condition met)
- Gra  out  1  select Ra field of IR for register-file read
- Rout  out  1  drive selected register onto bus
- CON_enable  out  1  condition flip-flop evaluate strobe
- PCout  out  1  drive PC onto bus
- Yin  out  1  load Y register
- Cout  out  1  drive sign-extended C field onto bus
- alu_add  out  1  ALU operation select = ADD
- Zin  out  1  load Z register
- Zlowout  out  1  drive Z[31:0] onto bus
- PCin  out  1  load PC from bus
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- taken  out  1  captured branch decision for the current/last branch
- illegal  out  1  one-cycle pulse: start with non-branch opcode
- taken_cnt  out  CNT_W  saturating count of taken branches
- exec_cnt  out  CNT_W  saturating count of executed branches

## Operation
- States: IDLE, T3, T4, T5, T6, FIN; one-hot or binary encoding, designer's choice.
- All control outputs are Moore outputs, decoded from the state register and registered flags only. There is no combinational path from any input to any output.
- IDLE: start=1 and IR[31:27]==BR_OPCODE -> T3. start=1 and opcode mismatch -> illegal asserted for the following cycle, stay IDLE. start=0 -> stay IDLE.
- T3: Gra, Rout, CON_enable = 1. At the closing edge, taken <= con_out -> T4.
- T4: PCout, Yin = 1 -> T5.
- T5: Cout, alu_add, Zin = 1 -> T6.
- T6: Zlowout = 1; PCin = taken. exec_cnt increments, and taken_cnt increments if taken=1. Each counter holds at all-ones and never wraps -> FIN.
- FIN: done = 1 -> IDLE.
- busy = 1 in T3..T6 and 0 in FIN and IDLE.
- start is ignored (no restart, no illegal pulse) whenever state != IDLE.
- taken holds its value from the end of T3 until the next T3 capture.
- clear (any time, including mid-sequence): state -> IDLE immediately. All outputs, including taken, taken_cnt and exec_cnt, go to 0. The CON_enable strobe is therefore dropped, and a partially executed branch never asserts PCin.

## Timing
- Reset value of every output: 0.
- Latency: start accepted at edge k. T3 runs during cycle k+1, T6 during k+4, done during k+5. The earliest next start is accepted at edge k+6, while the FSM is back in IDLE.
- CON_enable is high for exactly one cycle (T3), giving the condition flip-flop a single rising edge per branch. con_out must settle within the T3 cycle and is sampled only at the T3 closing edge.
- Counters update at the T6 closing edge. Their new values are visible during FIN.
- illegal: high for exactly one cycle, in the cycle after the rejecting start edge.
- Simultaneous clear and start: clear wins; start is lost.

## Test plan
- brzr taken: IR={BR_OPCODE,Ra=R3,C2=00,C=+4}, R3=0, con_out driven 1 in T3 -> strobes follow T3..T6 on consecutive cycles, PCin=1 in T6, taken=1, done at k+5, exec_cnt=1, taken_cnt=1.
- brnz not taken: C2=01, con_out 0 in T3 -> PCin=0 throughout, taken=0, exec_cnt=2, taken_cnt unchanged; con_out toggled to 1 during T4..T6 has no effect.
- Non-branch opcode 5'b00011 with start -> illegal pulses 1 cycle, busy stays 0, no strobes, counters unchanged.
- start re-pulsed during T4 and T5 -> ignored, sequence completes normally, exactly one done.
- clear asserted mid-T5 -> all outputs 0 immediately (asynchronous), no PCin, counters 0; a fresh start afterwards runs the full sequence.
- CNT_W=2, 5 taken branches back-to-back -> taken_cnt and exec_cnt saturate at 3, no wrap.
